// File: rtl/llmint_dual_path_sequencer.sv
// Mixed-precision linear step sequencer: forks data/weight handshakes to the low and
// high precision linears, joins their results, and steps IDLE -> WEIGHTS -> DRAIN per vector.

module llmint_dps_fork (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic x_valid,
  output logic x_ready,
  output logic lo_valid,
  input  logic lo_ready,
  output logic hi_valid,
  input  logic hi_ready,
  output logic pend
);
  logic done_lo, done_hi;

  // ready depends only on branch readies and flags, never on x_valid
  assign x_ready  = en & (lo_ready | done_lo) & (hi_ready | done_hi);
  assign lo_valid = x_valid & en & ~done_lo;
  assign hi_valid = x_valid & en & ~done_hi;
  assign pend     = done_lo | done_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_lo <= 1'b0;
      done_hi <= 1'b0;
    end else if (x_valid & x_ready) begin
      done_lo <= 1'b0;
      done_hi <= 1'b0;
    end else begin
      if (lo_valid & lo_ready) done_lo <= 1'b1;
      if (hi_valid & hi_ready) done_hi <= 1'b1;
    end
  end
endmodule

module llmint_dual_path_sequencer #(
  parameter int WEIGHT_BEATS = 8,
  parameter int OUT_BEATS    = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  input  logic                 weight_valid,
  output logic                 weight_ready,
  output logic                 lo_data_valid,
  input  logic                 lo_data_ready,
  output logic                 hi_data_valid,
  input  logic                 hi_data_ready,
  output logic                 lo_weight_valid,
  input  logic                 lo_weight_ready,
  output logic                 hi_weight_valid,
  input  logic                 hi_weight_ready,
  input  logic                 lo_out_valid,
  output logic                 lo_out_ready,
  input  logic                 hi_out_valid,
  output logic                 hi_out_ready,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] vec_count,
  output logic                 protocol_err
);
  localparam int NCH = 2;
  localparam int WW  = (WEIGHT_BEATS > 1) ? $clog2(WEIGHT_BEATS) : 1;
  localparam int OW  = $clog2(OUT_BEATS + 1);

  typedef enum logic [1:0] {IDLE, WEIGHTS, DRAIN} state_t;
  state_t         state;
  logic [WW-1:0]  w_cnt;
  logic [OW-1:0]  o_cnt;
  logic           o_full, en_o, d_fire, w_fire, o_fire;

  // channel 0 = input vector, channel 1 = weight beat
  logic [NCH-1:0] ch_en, ch_valid, ch_ready, ch_lo_v, ch_lo_r, ch_hi_v, ch_hi_r, ch_pend;

  assign ch_en    = {(state == WEIGHTS) & ~rst, (state == IDLE) & ~rst};
  assign ch_valid = {weight_valid, data_in_valid};
  assign ch_lo_r  = {lo_weight_ready, lo_data_ready};
  assign ch_hi_r  = {hi_weight_ready, hi_data_ready};

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_fork
      llmint_dps_fork u_fork (
        .clk      (clk),
        .rst      (rst),
        .en       (ch_en[c]),
        .x_valid  (ch_valid[c]),
        .x_ready  (ch_ready[c]),
        .lo_valid (ch_lo_v[c]),
        .lo_ready (ch_lo_r[c]),
        .hi_valid (ch_hi_v[c]),
        .hi_ready (ch_hi_r[c]),
        .pend     (ch_pend[c])
      );
    end
  endgenerate

  assign data_in_ready   = ch_ready[0];
  assign weight_ready    = ch_ready[1];
  assign lo_data_valid   = ch_lo_v[0];
  assign hi_data_valid   = ch_hi_v[0];
  assign lo_weight_valid = ch_lo_v[1];
  assign hi_weight_valid = ch_hi_v[1];

  // once the vector's result beats are in, the join closes so nothing extra is consumed
  assign o_full         = (o_cnt == OW'(OUT_BEATS));
  assign en_o           = (state != IDLE) & ~o_full & ~rst;
  assign data_out_valid = en_o & lo_out_valid & hi_out_valid;
  assign lo_out_ready   = en_o & data_out_ready & hi_out_valid;
  assign hi_out_ready   = en_o & data_out_ready & lo_out_valid;

  assign d_fire = data_in_valid & data_in_ready;
  assign w_fire = weight_valid & weight_ready;
  assign o_fire = data_out_valid & data_out_ready;
  assign busy   = (state != IDLE) | (|ch_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      w_cnt        <= '0;
      o_cnt        <= '0;
      vec_count    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if ((state == IDLE) & (lo_out_valid | hi_out_valid)) protocol_err <= 1'b1;
      case (state)
        IDLE: if (d_fire) state <= WEIGHTS;
        WEIGHTS: begin
          if (o_fire) o_cnt <= o_cnt + 1'b1;
          if (w_fire) begin
            if (w_cnt == WW'(WEIGHT_BEATS - 1)) begin
              w_cnt <= '0;
              state <= DRAIN;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (o_full | (o_fire & (o_cnt == OW'(OUT_BEATS - 1)))) begin
            state     <= IDLE;
            o_cnt     <= '0;
            vec_count <= vec_count + 1'b1;
          end else if (o_fire) begin
            o_cnt <= o_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_llmint_dual_path_sequencer.sv
// Bench for llmint_dual_path_sequencer: directed fork/join scenarios plus a
// scoreboard of expected vec_count at each joined result beat.
module tb_llmint_dual_path_sequencer;
  localparam int WB = 8;
  localparam int OB = 1;
  localparam int CW = 4;

  logic clk, rst;
  logic data_in_valid, data_in_ready, weight_valid, weight_ready;
  logic lo_data_valid, lo_data_ready, hi_data_valid, hi_data_ready;
  logic lo_weight_valid, lo_weight_ready, hi_weight_valid, hi_weight_ready;
  logic lo_out_valid, lo_out_ready, hi_out_valid, hi_out_ready;
  logic data_out_valid, data_out_ready, busy, protocol_err;
  logic [CW-1:0] vec_count;

  int checks = 0, failures = 0;
  int lo_d_hs = 0, hi_d_hs = 0, lo_w_hs = 0, hi_w_hs = 0;
  int b_ld, b_hd, b_lw, b_hw, sb_e;
  int exp_cnt = 0;
  int exp_q[$];

  llmint_dual_path_sequencer #(.WEIGHT_BEATS(WB), .OUT_BEATS(OB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .lo_data_valid(lo_data_valid), .lo_data_ready(lo_data_ready),
    .hi_data_valid(hi_data_valid), .hi_data_ready(hi_data_ready),
    .lo_weight_valid(lo_weight_valid), .lo_weight_ready(lo_weight_ready),
    .hi_weight_valid(hi_weight_valid), .hi_weight_ready(hi_weight_ready),
    .lo_out_valid(lo_out_valid), .lo_out_ready(lo_out_ready),
    .hi_out_valid(hi_out_valid), .hi_out_ready(hi_out_ready),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .busy(busy), .vec_count(vec_count), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_vec();
    data_in_valid = 1'b1; tick(); data_in_valid = 1'b0;
    exp_q.push_back(exp_cnt);
  endtask

  task automatic weights(input int n);
    weight_valid = 1'b1; repeat (n) tick(); weight_valid = 1'b0;
  endtask

  task automatic drain();
    lo_out_valid = 1'b1; hi_out_valid = 1'b1; tick();
    lo_out_valid = 1'b0; hi_out_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  task automatic do_vec();
    start_vec(); weights(WB); drain();
  endtask

  task automatic all_ready(input logic r);
    lo_data_ready = r; hi_data_ready = r; lo_weight_ready = r; hi_weight_ready = r;
  endtask

  // handshake counters and joined-beat scoreboard
  always @(negedge clk) if (!rst) begin
    if (lo_data_valid && lo_data_ready) lo_d_hs++;
    if (hi_data_valid && hi_data_ready) hi_d_hs++;
    if (lo_weight_valid && lo_weight_ready) lo_w_hs++;
    if (hi_weight_valid && hi_weight_ready) hi_w_hs++;
    if (data_out_valid && data_out_ready) begin
      chk("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk("sb_vec", vec_count, sb_e);
        chk("sb_join", {lo_out_ready, hi_out_ready}, 2'b11);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; data_in_valid = 0; weight_valid = 0; lo_out_valid = 0; hi_out_valid = 0;
    data_out_ready = 0; all_ready(1'b0);
    tick(); tick();
    @(negedge clk);
    chk("rst_din_rdy", data_in_ready, 0);
    chk("rst_w_rdy", weight_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", vec_count, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_dout_v", data_out_valid, 0);
    tick(); rst = 1'b0;

    // all branches ready: single data beat, 8 weights, one joined result
    all_ready(1'b1); data_out_ready = 1'b1;
    b_ld = lo_d_hs; b_hd = hi_d_hs; b_lw = lo_w_hs; b_hw = hi_w_hs;
    data_in_valid = 1'b1; weight_valid = 1'b1;
    @(negedge clk);
    chk("t1_din_rdy", data_in_ready, 1);
    chk("t1_fork_v", {lo_data_valid, hi_data_valid}, 2'b11);
    chk("t1_w_hold", {weight_ready, lo_weight_valid}, 2'b00);
    exp_q.push_back(exp_cnt);
    tick();
    @(negedge clk);
    chk("t1_din_hold", {data_in_ready, lo_data_valid}, 2'b00);
    chk("t1_w_rdy", weight_ready, 1);
    tick();
    repeat (WB - 1) tick();
    data_in_valid = 0; weight_valid = 0; lo_out_valid = 1; hi_out_valid = 1;
    @(negedge clk);
    chk("t1_drain", {data_out_valid, busy, weight_ready}, 3'b110);
    tick();
    lo_out_valid = 0; hi_out_valid = 0; exp_cnt = 1;
    @(negedge clk);
    chk("t1_cnt", vec_count, 1);
    chk("t1_idle", busy, 0);
    chk("t1_lo_d", lo_d_hs - b_ld, 1);
    chk("t1_hi_d", hi_d_hs - b_hd, 1);
    chk("t1_lo_w", lo_w_hs - b_lw, WB);
    chk("t1_hi_w", hi_w_hs - b_hw, WB);
    tick();

    // high data branch ready 3 cycles late
    b_ld = lo_d_hs; b_hd = hi_d_hs;
    hi_data_ready = 1'b0; data_in_valid = 1'b1;
    @(negedge clk);
    chk("t2_c0", {data_in_ready, lo_data_valid, hi_data_valid}, 3'b011);
    tick();
    @(negedge clk);
    chk("t2_c1", {data_in_ready, lo_data_valid, hi_data_valid, busy}, 4'b0011);
    tick();
    @(negedge clk);
    chk("t2_c2", data_in_ready, 0);
    tick();
    hi_data_ready = 1'b1;
    @(negedge clk);
    chk("t2_c3", {data_in_ready, lo_data_valid, hi_data_valid}, 3'b101);
    exp_q.push_back(exp_cnt);
    tick();
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("t2_weights", weight_ready, 1);
    chk("t2_lo_d", lo_d_hs - b_ld, 1);
    chk("t2_hi_d", hi_d_hs - b_hd, 1);
    tick();
    weights(WB);

    // high result arrives 2 cycles after low
    lo_out_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t3_wait", {lo_out_ready, data_out_valid}, 2'b00);
      tick();
    end
    hi_out_valid = 1'b1;
    @(negedge clk);
    chk("t3_join", {data_out_valid, lo_out_ready, hi_out_ready}, 3'b111);
    tick();
    lo_out_valid = 0; hi_out_valid = 0; exp_cnt = 2;
    @(negedge clk);
    chk("t3_done", {busy, vec_count}, {1'b0, 4'd2});
    tick();

    // downstream stall with both results valid
    start_vec(); weights(WB);
    data_out_ready = 1'b0; lo_out_valid = 1; hi_out_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall", {data_out_valid, lo_out_ready, hi_out_ready, busy}, 4'b1001);
      tick();
    end
    data_out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release", {data_out_valid, lo_out_ready, hi_out_ready}, 3'b111);
    tick();
    lo_out_valid = 0; hi_out_valid = 0; exp_cnt = 3;
    @(negedge clk);
    chk("t4_done", {busy, vec_count}, {1'b0, 4'd3});
    tick();

    // result joined during WEIGHTS: one DRAIN cycle then IDLE
    start_vec(); weights(3);
    weight_valid = 1; lo_out_valid = 1; hi_out_valid = 1;
    @(negedge clk);
    chk("t4b_early_out", {data_out_valid, weight_ready}, 2'b11);
    tick();
    lo_out_valid = 0; hi_out_valid = 0;
    weights(WB - 4);
    @(negedge clk);
    chk("t4b_drain", {busy, data_in_ready, data_out_valid}, 3'b100);
    tick();
    exp_cnt = 4;
    @(negedge clk);
    chk("t4b_idle", {busy, data_in_ready, vec_count}, {2'b01, 4'd4});
    tick();

    // reset mid-WEIGHTS with a partially forked beat
    start_vec(); weights(4);
    hi_weight_ready = 1'b0; weight_valid = 1'b1;
    @(negedge clk);
    chk("t5_part", {weight_ready, lo_weight_valid, hi_weight_valid}, 3'b011);
    tick();
    @(negedge clk);
    chk("t5_done_lo", {lo_weight_valid, hi_weight_valid, busy}, 3'b011);
    rst = 1'b1; weight_valid = 0; all_ready(1'b0);
    tick();
    rst = 1'b0; exp_q.delete(); exp_cnt = 0;
    @(negedge clk);
    chk("t5_quiet", {data_in_ready, weight_ready, lo_data_valid, hi_data_valid, lo_weight_valid,
                     hi_weight_valid, lo_out_ready, hi_out_ready, data_out_valid, busy}, 0);
    chk("t5_cnt", vec_count, 0);
    tick();
    all_ready(1'b1); weight_valid = 1'b1;
    @(negedge clk);
    chk("t5_idle_w_hold", {weight_ready, lo_weight_valid}, 2'b00);
    tick();
    weight_valid = 1'b0;
    b_lw = lo_w_hs; b_hw = hi_w_hs;
    do_vec();
    @(negedge clk);
    chk("t5_recover_cnt", vec_count, 1);
    chk("t5_recover_lo_w", lo_w_hs - b_lw, WB);
    chk("t5_recover_hi_w", hi_w_hs - b_hw, WB);
    tick();

    // stray result in IDLE flags a sticky protocol error
    lo_out_valid = 1'b1;
    @(negedge clk);
    chk("t6_idle_out", {lo_out_ready, data_out_valid, protocol_err}, 3'b000);
    tick();
    lo_out_valid = 1'b0;
    @(negedge clk);
    chk("t6_perr", protocol_err, 1);
    tick();
    do_vec();
    @(negedge clk);
    chk("t6_sticky", protocol_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_cnt = 0; exp_q.delete();
    @(negedge clk);
    chk("t6_perr_clr", {protocol_err, vec_count}, 0);
    tick();

    // vec_count wrap
    repeat ((1 << CW) - 1) do_vec();
    @(negedge clk);
    chk("t6_max", vec_count, (1 << CW) - 1);
    tick();
    do_vec();
    @(negedge clk);
    chk("t6_wrap", vec_count, 0);
    chk("sb_empty", exp_q.size(), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
